// File: rtl/seq_divmod.sv
// Restoring radix-2 unsigned divider: one quotient bit per clock, MSB first.
// quot/rem/div_by_zero are registered and change only on the edge that raises done.
module seq_divmod #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] quot,
    output logic [DATAWIDTH-1:0] rem,
    output logic                 div_by_zero
);

    localparam int CW = $clog2(DATAWIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DATAWIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [DATAWIDTH-1:0]   dvd_q;
    logic [DATAWIDTH-1:0]   dvs_q;
    logic [DATAWIDTH-1:0]   prem_q;
    logic                   zero_q;
    logic                   busy_q;
    logic                   done_q;
    logic [DATAWIDTH-1:0]   quot_q;
    logic [DATAWIDTH-1:0]   rem_q;
    logic                   dbz_q;

    logic [DATAWIDTH:0]     trial_s;
    logic [DATAWIDTH:0]     diff_s;
    logic                   fits_s;
    logic [DATAWIDTH-1:0]   prem_d;
    logic [DATAWIDTH-1:0]   dvd_d;

    // One restoring step. For a nonzero divisor the partial remainder is always
    // below it, so bit DATAWIDTH of the difference is exactly the borrow.
    always_comb begin
        trial_s = {prem_q, dvd_q[DATAWIDTH-1]};
        diff_s  = trial_s - {1'b0, dvs_q};
        fits_s  = zero_q | ~diff_s[DATAWIDTH];
        if (fits_s) begin
            prem_d = diff_s[DATAWIDTH-1:0];
            dvd_d  = {dvd_q[DATAWIDTH-2:0], 1'b1};
        end else begin
            prem_d = trial_s[DATAWIDTH-1:0];
            dvd_d  = {dvd_q[DATAWIDTH-2:0], 1'b0};
        end
    end

    // Control FSM with datapath and registered outputs.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            dvd_q   <= {DATAWIDTH{1'b0}};
            dvs_q   <= {DATAWIDTH{1'b0}};
            prem_q  <= {DATAWIDTH{1'b0}};
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= {DATAWIDTH{1'b0}};
            rem_q   <= {DATAWIDTH{1'b0}};
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dvd_q   <= a;
                        dvs_q   <= b;
                        prem_q  <= {DATAWIDTH{1'b0}};
                        zero_q  <= (b == {DATAWIDTH{1'b0}});
                        cnt_q   <= CNT_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    prem_q <= prem_d;
                    dvd_q  <= dvd_d;
                    cnt_q  <= cnt_q - CNT_ONE;
                    busy_q <= 1'b1;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= FINISH;
                    end else begin
                        state_q <= RUN;
                    end
                end
                FINISH: begin
                    // busy drops for the done cycle even when a new operand pair is accepted
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    quot_q <= dvd_q;
                    rem_q  <= prem_q;
                    dbz_q  <= zero_q;
                    if (start) begin
                        dvd_q   <= a;
                        dvs_q   <= b;
                        prem_q  <= {DATAWIDTH{1'b0}};
                        zero_q  <= (b == {DATAWIDTH{1'b0}});
                        cnt_q   <= CNT_LOAD;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quot        = quot_q;
    assign rem         = rem_q;
    assign div_by_zero = dbz_q;

endmodule
